// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg: shared request type, defaults and FSM state encoding for the instruction memory responder
package instr_mem_responder_pkg;
  localparam int ICACHE_LINE_WIDTH = 128;
  localparam int PHY_ADDR_RANGE = 32;
  localparam int INSTR_MEM_LATENCY_DEF = 10;
  localparam int INSTR_MEM_LINES_DEF = 1024;
  typedef struct packed {
    logic [PHY_ADDR_RANGE-1:0] addr;
    logic is_store;
    logic [ICACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} instr_mem_state_t;
endpackage

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: miss request/response bus between the instruction cache and its memory responder
interface instr_mem_responder_if;
  import instr_mem_responder_pkg::*;
  logic req_valid_miss;
  memory_request_t req_info_miss;
  logic req_ready;
  logic rsp_valid_miss;
  logic [ICACHE_LINE_WIDTH-1:0] rsp_data_miss;
  logic rsp_bus_error;
  logic req_dropped;
  modport master (
    output req_valid_miss, req_info_miss,
    input req_ready, rsp_valid_miss, rsp_data_miss, rsp_bus_error, req_dropped
  );
  modport slave (
    input req_valid_miss, req_info_miss,
    output req_ready, rsp_valid_miss, rsp_data_miss, rsp_bus_error, req_dropped
  );
endinterface

// File: rtl/instr_mem_responder_mem_line_array.sv
// mem_line_array: single-port line-wide RAM, synchronous write and combinational read of registered storage
module mem_line_array #(
  parameter int LINES = 1024,
  parameter int WIDTH = 128
) (
  input logic clock,
  input logic we,
  input logic [$clog2(LINES)-1:0] index,
  input logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [LINES];
  always_ff @(posedge clock) if (we) mem[index] <= wdata;
  assign rdata = mem[index];
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency line read/store responder; INSTR_MEM_BUS_ERROR_EN enables out-of-range bus errors
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int MEM_LINES = INSTR_MEM_LINES_DEF,
  parameter int LATENCY = INSTR_MEM_LATENCY_DEF
) (
  input logic clock,
  input logic reset,
  instr_mem_responder_if.slave bus
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int OB = $clog2(ICACHE_LINE_WIDTH / 8);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;
  logic [1:0] state, next;
  logic [7:0] cnt;
  logic [IW-1:0] lat_idx, idx;
  logic lat_store, lat_err, req_err, accept, we, go_rsp, cur_rd, cur_err;
  logic [ICACHE_LINE_WIDTH-1:0] lat_data, rdata, rsp_data;
  logic [PHY_ADDR_RANGE-OB-1:0] full_idx;
  logic rsp_valid, rsp_err, dropped;
  assign full_idx = bus.req_info_miss.addr[PHY_ADDR_RANGE-1:OB];
`ifdef INSTR_MEM_BUS_ERROR_EN
  assign req_err = |(full_idx >> IW);
`else
  assign req_err = 1'b0;
`endif
  assign accept = bus.req_valid_miss & bus.req_ready;
  assign idx = state == S_IDLE ? full_idx[IW-1:0] : lat_idx;
  assign we = state == S_RESP & lat_store & ~lat_err;
  // with LATENCY==1 the response is built from the incoming request instead of the latch
  assign cur_err = state == S_IDLE ? req_err : lat_err;
  assign cur_rd = state == S_IDLE ? ~bus.req_info_miss.is_store & ~req_err : ~lat_store & ~lat_err;
  assign go_rsp = next == S_RESP;
  always_comb
    next = state == S_IDLE ? (accept ? (LATENCY == 1 ? S_RESP : S_WAIT) : S_IDLE) :
           state == S_WAIT ? (cnt == 8'd1 ? S_RESP : S_WAIT) : S_IDLE;
  mem_line_array #(.LINES(MEM_LINES), .WIDTH(ICACHE_LINE_WIDTH)) u_array (
    .clock(clock), .we(we), .index(idx), .wdata(lat_data), .rdata(rdata)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      dropped <= 1'b0;
    end else begin
      state <= next;
      cnt <= accept ? 8'(LATENCY - 1) : state == S_WAIT ? cnt - 8'd1 : cnt;
      rsp_valid <= go_rsp;
      rsp_err <= go_rsp & cur_err;
      rsp_data <= go_rsp & cur_rd ? rdata : '0;
      dropped <= dropped | (bus.req_valid_miss & ~bus.req_ready);
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      lat_idx <= full_idx[IW-1:0];
      lat_store <= bus.req_info_miss.is_store;
      lat_err <= req_err;
      lat_data <= bus.req_info_miss.data;
    end
  end
  assign bus.req_ready = state == S_IDLE;
  assign bus.rsp_valid_miss = rsp_valid;
  assign bus.rsp_data_miss = rsp_data;
  assign bus.req_dropped = dropped;
`ifdef INSTR_MEM_BUS_ERROR_EN
  assign bus.rsp_bus_error = rsp_err;
`else
  assign bus.rsp_bus_error = 1'b0;
`endif
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: randomized scoreboard bench with a line-array reference model
module tb_instr_mem_responder;
  import instr_mem_responder_pkg::*;
  localparam int L = INSTR_MEM_LATENCY_DEF;
  localparam int N = INSTR_MEM_LINES_DEF;
  localparam int W = ICACHE_LINE_WIDTH;
  typedef struct {
    logic [W-1:0] data;
    logic err;
    int at;
  } exp_t;
  logic clock = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] model [N];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  instr_mem_responder_if bus();
  instr_mem_responder #(.MEM_LINES(N), .LATENCY(L)) dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic bit is_err(input logic [31:0] a);
`ifdef INSTR_MEM_BUS_ERROR_EN
    return (a / 16) >= N;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int line_of(input logic [31:0] a);
    return int'((a / 16) % N);
  endfunction
  always @(negedge clock) begin
    if (!reset && bus.rsp_valid_miss) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b with nothing outstanding (cycle %0d)",
                 bus.rsp_data_miss, bus.rsp_bus_error, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_cycle", W'(cyc), W'(mon_e.at));
        chk("rsp_data", bus.rsp_data_miss, mon_e.data);
        chk("rsp_err", W'(bus.rsp_bus_error), W'(mon_e.err));
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask
  task automatic issue(input logic [31:0] a, input bit st, input logic [W-1:0] d, input bit expect_rsp, output int t);
    exp_t e;
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1 within 100 cycles");
    end
    bus.req_valid_miss = 1'b1;
    bus.req_info_miss = '{addr: a, is_store: st, data: d};
    t = cyc;
    if (expect_rsp) begin
      e.err = is_err(a);
      e.data = (st || e.err) ? '0 : model[line_of(a)];
      e.at = t + L;
      q.push_back(e);
      if (st && !e.err) model[line_of(a)] = d;
    end
    step();
    bus.req_valid_miss = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    step();
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, W'(bus.rsp_valid_miss), '0);
    chk({tag, "_rsp_data"}, bus.rsp_data_miss, '0);
    chk({tag, "_rsp_err"}, W'(bus.rsp_bus_error), '0);
    chk({tag, "_req_ready"}, W'(bus.req_ready), W'(1));
    chk({tag, "_req_dropped"}, W'(bus.req_dropped), '0);
  endtask
  function automatic logic [W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    int t;
    logic [31:0] a;
    logic [W-1:0] pat;
    bus.req_valid_miss = 1'b0;
    bus.req_info_miss = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_reset_outputs("reset");
    for (int i = 0; i < 16; i++) begin
      pat = (i == 4) ? 128'hDEADBEEF_00000001_00000002_00000003 : rnd_line();
      issue(32'(i * 16), 1'b1, pat, 1'b1, t);
    end
    wait_idle();
    issue(32'h40, 1'b0, '0, 1'b1, t);
    wait_until(t + L);
    chk("ready_during_resp", W'(bus.req_ready), '0);
    step();
    chk("ready_after_resp", W'(bus.req_ready), W'(1));
    issue(32'h104, 1'b1, {16{8'hA5}}, 1'b1, t);
    issue(32'h100, 1'b0, '0, 1'b1, t);
    issue(32'h4000, 1'b0, '0, 1'b1, t);
    issue(32'h4000, 1'b1, {16{8'h3C}}, 1'b1, t);
    issue(32'h0, 1'b0, '0, 1'b1, t);
    wait_idle();
    issue(32'h40, 1'b0, '0, 1'b1, t);
    wait_until(t + 3);
    chk("dropped_before_overlap", W'(bus.req_dropped), '0);
    bus.req_valid_miss = 1'b1;
    bus.req_info_miss = '{addr: 32'h50, is_store: 1'b1, data: rnd_line()};
    step();
    bus.req_valid_miss = 1'b0;
    chk("dropped_after_overlap", W'(bus.req_dropped), W'(1));
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      a = 32'(($urandom_range(0, 15) << 4) | $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 255) << 14);
      issue(a, 1'($urandom_range(0, 1)), rnd_line(), 1'b1, t);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    chk("dropped_sticky", W'(bus.req_dropped), W'(1));
    issue(32'h70, 1'b1, rnd_line(), 1'b0, t);
    wait_until(t + 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_outputs("midop");
    repeat (L + 3) step();
    issue(32'h78, 1'b0, '0, 1'b1, t);
    wait_idle();
    chk("queue_drained", W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
